// File: rtl/alu_if.sv
// Byte-serial operand/result bus for the alu coprocessor.
// valid/ready semantics: the master raises valid for one cycle with X on
// `in` and the opcode on `op_codes`; the following cycle `in` carries Y.
// valid is only honoured while the slave is idle. The slave answers with
// ready high for exactly two consecutive cycles, low result byte first and
// then the high byte, and holds `o` at zero whenever ready is low.
// dbg_state mirrors the slave FSM state for observation.
interface alu_if;
  logic [7:0] in;
  logic [1:0] op_codes;
  logic       valid;
  logic [7:0] o;
  logic       ready;
  logic [2:0] dbg_state;

  modport master (
    output in, op_codes, valid,
    input  o, ready, dbg_state
  );

  modport slave (
    input  in, op_codes, valid,
    output o, ready, dbg_state
  );
endinterface

// File: rtl/alu.sv
// Multi-cycle 8-bit ALU: add, sub, signed Booth multiply and unsigned
// restoring divide. Operands arrive as two bytes, the 16-bit result leaves
// as two bytes (low then high) while ready is high.
// Optional macro ALU_BUSY_EN adds a `busy` output that is high from
// operand acceptance until the result has been fully presented.
module alu (
  input  logic clk,
  input  logic rst,
`ifdef ALU_BUSY_EN
  output logic busy,
`endif
  alu_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_Y = 3'd1,
    EXEC   = 3'd2,
    OUT_LO = 3'd3,
    OUT_HI = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_x, w_x_nxt;
  logic [1:0] r_op, w_op_nxt;
  logic [7:0] r_a, w_a_nxt;
  logic [7:0] r_q, w_q_nxt;
  logic       r_q1, w_q1_nxt;
  logic [7:0] r_m, w_m_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_hi, w_hi_nxt;
  logic [7:0] r_o, w_o_nxt;
  logic       r_ready, w_ready_nxt;

  // Add/sub results (bit 8 is carry for add, borrow for sub).
  logic [8:0] w_add;
  logic [8:0] w_sub;

  // One Booth iteration: conditional add/sub of M, then arithmetic shift.
  logic [7:0] w_booth_sum;
  logic [7:0] w_booth_a;
  logic [7:0] w_booth_q;
  logic       w_booth_q1;

  // One restoring-divide iteration on a 9-bit shifted partial remainder so
  // divisors above 127 never lose the top bit.
  logic [8:0] w_div_sh;
  logic       w_div_neg;
  logic [7:0] w_div_a;
  logic [7:0] w_div_q;

  // Single-step arithmetic shared by all operations.
  always_comb begin
    w_add = {1'b0, r_x} + {1'b0, r_m};
    w_sub = {1'b0, r_x} - {1'b0, r_m};

    case ({r_q[0], r_q1})
      2'b01:   w_booth_sum = r_a + r_m;
      2'b10:   w_booth_sum = r_a - r_m;
      default: w_booth_sum = r_a;
    endcase
    w_booth_a  = {w_booth_sum[7], w_booth_sum[7:1]};
    w_booth_q  = {w_booth_sum[0], r_q[7:1]};
    w_booth_q1 = r_q[0];

    w_div_sh  = {r_a, r_q[7]};
    w_div_neg = (w_div_sh < {1'b0, r_m});
    if (w_div_neg) begin
      w_div_a = w_div_sh[7:0];
      w_div_q = {r_q[6:0], 1'b0};
    end else begin
      w_div_a = w_div_sh[7:0] - r_m;
      w_div_q = {r_q[6:0], 1'b1};
    end
  end

  // Next-state, datapath update and next registered output values.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_q_nxt     = r_q;
    w_q1_nxt    = r_q1;
    w_m_nxt     = r_m;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_o_nxt     = 8'h00;
    w_ready_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.valid == 1'b1) begin
          w_x_nxt     = bus.in;
          w_op_nxt    = bus.op_codes;
          w_state_nxt = LOAD_Y;
        end
      end

      LOAD_Y: begin
        w_m_nxt     = bus.in;
        w_a_nxt     = 8'h00;
        w_q1_nxt    = 1'b0;
        w_cnt_nxt   = 3'd0;
        w_q_nxt     = ((r_op == OP_MUL) || (r_op == OP_DIV)) ? r_x : 8'h00;
        w_state_nxt = EXEC;
      end

      EXEC: begin
        case (r_op)
          OP_ADD: begin
            w_o_nxt     = w_add[7:0];
            w_hi_nxt    = {7'b0, w_add[8]};
            w_ready_nxt = 1'b1;
            w_state_nxt = OUT_LO;
          end
          OP_SUB: begin
            w_o_nxt     = w_sub[7:0];
            w_hi_nxt    = {7'b0, w_sub[8]};
            w_ready_nxt = 1'b1;
            w_state_nxt = OUT_LO;
          end
          OP_MUL: begin
            w_a_nxt   = w_booth_a;
            w_q_nxt   = w_booth_q;
            w_q1_nxt  = w_booth_q1;
            w_cnt_nxt = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_o_nxt     = w_booth_q;
              w_hi_nxt    = w_booth_a;
              w_ready_nxt = 1'b1;
              w_state_nxt = OUT_LO;
            end
          end
          default: begin
            w_a_nxt   = w_div_a;
            w_q_nxt   = w_div_q;
            w_cnt_nxt = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              // Divide by zero still runs all iterations, then reports
              // an all-ones quotient and the dividend as remainder.
              if (r_m == 8'h00) begin
                w_o_nxt  = 8'hFF;
                w_hi_nxt = r_x;
              end else begin
                w_o_nxt  = w_div_q;
                w_hi_nxt = w_div_a;
              end
              w_ready_nxt = 1'b1;
              w_state_nxt = OUT_LO;
            end
          end
        endcase
      end

      OUT_LO: begin
        w_o_nxt     = r_hi;
        w_ready_nxt = 1'b1;
        w_state_nxt = OUT_HI;
      end

      OUT_HI: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_x     <= 8'h00;
      r_op    <= 2'b00;
      r_a     <= 8'h00;
      r_q     <= 8'h00;
      r_q1    <= 1'b0;
      r_m     <= 8'h00;
      r_cnt   <= 3'd0;
      r_hi    <= 8'h00;
      r_o     <= 8'h00;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_q     <= w_q_nxt;
      r_q1    <= w_q1_nxt;
      r_m     <= w_m_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_o     <= w_o_nxt;
      r_ready <= w_ready_nxt;
    end
  end

`ifdef ALU_BUSY_EN
  logic r_busy;

  // Busy tracks every non-idle state, registered like the other outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
    end
  end

  assign busy = r_busy;
`endif

  assign bus.o         = r_o;
  assign bus.ready     = r_ready;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu: reset, each operation, divide by zero,
// protocol (held valid, back-to-back) and asynchronous reset mid-operation.
module tb_alu;

  logic clk;
  logic rst;
`ifdef ALU_BUSY_EN
  logic busy;
`endif

  alu_if bus ();

  alu dut (
    .clk  (clk),
    .rst  (rst),
`ifdef ALU_BUSY_EN
    .busy (busy),
`endif
    .bus  (bus)
  );

  int checks;
  int errors;

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: caller is #1 after an edge with the DUT idle. Returns the
  // captured result pair, the edge index at which ready first appeared
  // (0 on timeout), ready during the high byte and ready afterwards.
  task automatic issue(input logic [1:0] op, input logic [7:0] x,
                       input logic [7:0] y, output logic [7:0] lo,
                       output logic [7:0] hi, output int lat,
                       output logic rdy_hi, output logic rdy_end);
    lo = 8'h00; hi = 8'h00; lat = 0; rdy_hi = 1'b0; rdy_end = 1'b1;
    bus.valid = 1'b1; bus.op_codes = op; bus.in = x;
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.op_codes = ~op; bus.in = y;
    @(posedge clk); #1;
    bus.in = 8'($urandom_range(0, 255));
    for (int n = 2; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.ready === 1'b1) begin
        lat = n;
        lo  = bus.o;
        break;
      end
    end
    if (lat != 0) begin
      @(posedge clk); #1;
      rdy_hi = bus.ready;
      hi     = bus.o;
      @(posedge clk); #1;
      rdy_end = bus.ready;
    end
  endtask

  task automatic test_reset;
    logic [11:0] got, exp;
    rst = 1'b0; bus.valid = 1'b0; bus.in = 8'h00; bus.op_codes = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    got = {bus.o, bus.ready, bus.dbg_state};
    exp = 12'h000;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", got, exp);
    end
`ifdef ALU_BUSY_EN
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    got = {bus.o, bus.ready, bus.dbg_state};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL idle_after_reset got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_add_sub;
    logic [7:0] lo, hi; int lat; logic rh, re;
    logic [25:0] got, exp;
    issue(2'b00, 8'd200, 8'd100, lo, hi, lat, rh, re);
    got = {8'(lat), lo, hi, rh, re}; exp = {8'd2, 8'd44, 8'd1, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL add_200_100 got=%h exp=%h", got, exp); end
    issue(2'b01, 8'd5, 8'd10, lo, hi, lat, rh, re);
    got = {8'(lat), lo, hi, rh, re}; exp = {8'd2, 8'd251, 8'd1, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL sub_5_10 got=%h exp=%h", got, exp); end
    issue(2'b01, 8'd10, 8'd5, lo, hi, lat, rh, re);
    got = {8'(lat), lo, hi, rh, re}; exp = {8'd2, 8'd5, 8'd0, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL sub_10_5 got=%h exp=%h", got, exp); end
  endtask

  task automatic test_mul;
    logic [7:0] lo, hi; int lat; logic rh, re;
    logic [25:0] got, exp;
    issue(2'b10, 8'hFD, 8'd7, lo, hi, lat, rh, re);
    got = {8'(lat), lo, hi, rh, re}; exp = {8'd9, 8'hEB, 8'hFF, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL mul_m3_7 got=%h exp=%h", got, exp); end
    issue(2'b10, 8'd12, 8'd11, lo, hi, lat, rh, re);
    got = {8'(lat), lo, hi, rh, re}; exp = {8'd9, 8'd132, 8'd0, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL mul_12_11 got=%h exp=%h", got, exp); end
    issue(2'b10, 8'h80, 8'd1, lo, hi, lat, rh, re);
    got = {8'(lat), lo, hi, rh, re}; exp = {8'd9, 8'h80, 8'hFF, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL mul_m128_1 got=%h exp=%h", got, exp); end
  endtask

  task automatic test_div;
    logic [7:0] lo, hi; int lat; logic rh, re;
    logic [25:0] got, exp;
    issue(2'b11, 8'd10, 8'd5, lo, hi, lat, rh, re);
    got = {8'(lat), lo, hi, rh, re}; exp = {8'd9, 8'd2, 8'd0, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL div_10_5 got=%h exp=%h", got, exp); end
    issue(2'b11, 8'd200, 8'd7, lo, hi, lat, rh, re);
    got = {8'(lat), lo, hi, rh, re}; exp = {8'd9, 8'd28, 8'd4, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL div_200_7 got=%h exp=%h", got, exp); end
    issue(2'b11, 8'd37, 8'd0, lo, hi, lat, rh, re);
    got = {8'(lat), lo, hi, rh, re}; exp = {8'd9, 8'hFF, 8'd37, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL div_by_zero got=%h exp=%h", got, exp); end
    issue(2'b11, 8'd250, 8'd200, lo, hi, lat, rh, re);
    got = {8'(lat), lo, hi, rh, re}; exp = {8'd9, 8'd1, 8'd50, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL div_250_200 got=%h exp=%h", got, exp); end
  endtask

  task automatic test_hold_valid;
    logic [7:0] lo, hi; int cnt; logic re;
    logic [22:0] got, exp;
    lo = 8'h00; hi = 8'h00; cnt = 0;
    bus.valid = 1'b1; bus.op_codes = 2'b10; bus.in = 8'd3;
    @(posedge clk); #1;
    bus.in = 8'd5;
`ifdef ALU_BUSY_EN
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept got=%b exp=1", busy); end
`endif
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (bus.ready === 1'b1) begin
        cnt++;
        if (n == 9)  lo = bus.o;
        if (n == 10) hi = bus.o;
      end
    end
    bus.valid = 1'b0;
    @(posedge clk); #1;
    re = bus.ready;
    got = {8'(cnt), lo, hi, re, bus.dbg_state};
    exp = {8'd2, 8'd15, 8'd0, 1'b0, 3'd0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL hold_valid_mul got=%h exp=%h", got, exp); end
`ifdef ALU_BUSY_EN
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done got=%b exp=0", busy); end
`endif
  endtask

  task automatic test_back_to_back;
    logic [7:0] lo, hi; int lat; logic rh, re;
    logic [25:0] got, exp;
    issue(2'b00, 8'd7, 8'd9, lo, hi, lat, rh, re);
    got = {8'(lat), lo, hi, rh, re}; exp = {8'd2, 8'd16, 8'd0, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL b2b_add_7_9 got=%h exp=%h", got, exp); end
    issue(2'b00, 8'd100, 8'd156, lo, hi, lat, rh, re);
    got = {8'(lat), lo, hi, rh, re}; exp = {8'd2, 8'd0, 8'd1, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL b2b_add_carry got=%h exp=%h", got, exp); end
    issue(2'b01, 8'd0, 8'd1, lo, hi, lat, rh, re);
    got = {8'(lat), lo, hi, rh, re}; exp = {8'd2, 8'hFF, 8'd1, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL b2b_sub_0_1 got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] lo, hi; int lat; logic rh, re;
    logic [25:0] got, exp;
    logic [11:0] sgot;
    // Reset asserted between edges while a multiply is iterating.
    bus.valid = 1'b1; bus.op_codes = 2'b10; bus.in = 8'hFD;
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.in = 8'd7;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    sgot = {bus.o, bus.ready, bus.dbg_state};
    checks++;
    if (sgot !== 12'h000) begin errors++; $display("FAIL reset_mid_exec got=%h exp=000", sgot); end
    @(posedge clk); #1;
    rst = 1'b1;
    // Reset asserted while the low result byte is being presented.
    bus.valid = 1'b1; bus.op_codes = 2'b00; bus.in = 8'd3;
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.in = 8'd4;
    repeat (2) @(posedge clk);
    #1;
    sgot = {bus.o, bus.ready, bus.dbg_state};
    checks++;
    if (sgot !== {8'd7, 1'b1, 3'd3}) begin errors++; $display("FAIL pre_reset_out_lo got=%h exp=%h", sgot, {8'd7, 1'b1, 3'd3}); end
    #2;
    rst = 1'b0;
    #1;
    sgot = {bus.o, bus.ready, bus.dbg_state};
    checks++;
    if (sgot !== 12'h000) begin errors++; $display("FAIL reset_mid_out got=%h exp=000", sgot); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    issue(2'b00, 8'd1, 8'd1, lo, hi, lat, rh, re);
    got = {8'(lat), lo, hi, rh, re}; exp = {8'd2, 8'd2, 8'd0, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL add_after_reset got=%h exp=%h", got, exp); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_hold_valid();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
